// File: rtl/mips_id_stage.sv
// ============================================================================
// Module   : mips_id_stage
// Function : MIPS ID stage: 32x32 register file, control decode, sign
//            extension and the ID/EX pipeline latch.
//            Optional macro WB_ADDR_PORT_EN adds the mem_wb_writereg port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] if_id_npc,
    input  logic [31:0] mem_wb_writedata,
    input  logic        regWrite,
`ifdef WB_ADDR_PORT_EN
    input  logic [4:0]  mem_wb_writereg,
`endif
    output logic [1:0]  id_ex_wb,
    output logic [2:0]  id_ex_m,
    output logic [3:0]  id_ex_ex,
    output logic [31:0] id_ex_npc,
    output logic [31:0] id_ex_reg1,
    output logic [31:0] id_ex_reg2,
    output logic [31:0] id_ex_sign_ext,
    output logic [4:0]  id_ex_instr20_16,
    output logic [4:0]  id_ex_instr15_11
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [31:0] regs_q [32];

    logic [1:0]  wb_q,  wb_d;
    logic [2:0]  m_q,   m_d;
    logic [3:0]  ex_q,  ex_d;
    logic [31:0] npc_q, reg1_q, reg2_q, sext_q;
    logic [31:0] reg1_d, reg2_d, sext_d;
    logic [4:0]  rt_q,  rd_q;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
    logic        w_we;

    assign w_opcode = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];

`ifdef WB_ADDR_PORT_EN
    assign w_waddr = mem_wb_writereg;
`else
    assign w_waddr = (w_opcode == OP_RTYPE) ? w_rd : w_rt;
`endif

    // Register 0 is hardwired, so a write to it is simply dropped.
    assign w_we = regWrite && (w_waddr != 5'd0);

    always_comb begin
        wb_d = 2'b00;
        m_d  = 3'b000;
        ex_d = 4'b0000;
        case (w_opcode)
            OP_RTYPE: begin wb_d = 2'b10; m_d = 3'b000; ex_d = 4'b1100; end
            OP_LW:    begin wb_d = 2'b11; m_d = 3'b010; ex_d = 4'b0001; end
            OP_SW:    begin wb_d = 2'b00; m_d = 3'b001; ex_d = 4'b0001; end
            OP_BEQ:   begin wb_d = 2'b00; m_d = 3'b100; ex_d = 4'b0010; end
            OP_ADDI:  begin wb_d = 2'b10; m_d = 3'b000; ex_d = 4'b0001; end
            default:  begin wb_d = 2'b00; m_d = 3'b000; ex_d = 4'b0000; end
        endcase
    end

    // Reads bypass the write port so a same-cycle write is seen immediately.
    always_comb begin
        reg1_d = regs_q[w_rs];
        reg2_d = regs_q[w_rt];
        if (w_we && (w_waddr == w_rs)) reg1_d = mem_wb_writedata;
        if (w_we && (w_waddr == w_rt)) reg2_d = mem_wb_writedata;
        if (w_rs == 5'd0) reg1_d = 32'd0;
        if (w_rt == 5'd0) reg2_d = 32'd0;
    end

    assign sext_d = {{16{instr[15]}}, instr[15:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            wb_q   <= '0;
            m_q    <= '0;
            ex_q   <= '0;
            npc_q  <= '0;
            reg1_q <= '0;
            reg2_q <= '0;
            sext_q <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            if (w_we) begin
                regs_q[w_waddr] <= mem_wb_writedata;
            end
            wb_q   <= wb_d;
            m_q    <= m_d;
            ex_q   <= ex_d;
            npc_q  <= if_id_npc;
            reg1_q <= reg1_d;
            reg2_q <= reg2_d;
            sext_q <= sext_d;
            rt_q   <= w_rt;
            rd_q   <= w_rd;
        end
    end

    assign id_ex_wb         = wb_q;
    assign id_ex_m          = m_q;
    assign id_ex_ex         = ex_q;
    assign id_ex_npc        = npc_q;
    assign id_ex_reg1       = reg1_q;
    assign id_ex_reg2       = reg2_q;
    assign id_ex_sign_ext   = sext_q;
    assign id_ex_instr20_16 = rt_q;
    assign id_ex_instr15_11 = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_id_stage.sv
// ============================================================================
// Module   : tb_mips_id_stage
// Function : Directed self-checking bench for mips_id_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] if_id_npc;
    logic [31:0] mem_wb_writedata;
    logic        regWrite;
`ifdef WB_ADDR_PORT_EN
    logic [4:0]  mem_wb_writereg;
`endif
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_reg1;
    logic [31:0] id_ex_reg2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_instr20_16;
    logic [4:0]  id_ex_instr15_11;

    int checks;
    int errors;

    mips_id_stage dut (
        .clk              (clk),
        .rst              (rst),
        .instr            (instr),
        .if_id_npc        (if_id_npc),
        .mem_wb_writedata (mem_wb_writedata),
        .regWrite         (regWrite),
`ifdef WB_ADDR_PORT_EN
        .mem_wb_writereg  (mem_wb_writereg),
`endif
        .id_ex_wb         (id_ex_wb),
        .id_ex_m          (id_ex_m),
        .id_ex_ex         (id_ex_ex),
        .id_ex_npc        (id_ex_npc),
        .id_ex_reg1       (id_ex_reg1),
        .id_ex_reg2       (id_ex_reg2),
        .id_ex_sign_ext   (id_ex_sign_ext),
        .id_ex_instr20_16 (id_ex_instr20_16),
        .id_ex_instr15_11 (id_ex_instr15_11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs across a single rising edge, sample 1 ns later.
    task automatic drive(input logic r, input logic [31:0] ins, input logic we,
                         input logic [31:0] wdata, input logic [4:0] wreg);
        rst              = r;
        instr            = ins;
        regWrite         = we;
        mem_wb_writedata = wdata;
`ifdef WB_ADDR_PORT_EN
        mem_wb_writereg  = wreg;
`else
        if (wreg != 5'd0) begin end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        if_id_npc = 32'h1000_0000;
        drive(1'b0, 32'h8C12_0000, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_reg1, id_ex_reg2,
             id_ex_sign_ext, id_ex_instr20_16, id_ex_instr15_11} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got wb=%b m=%b ex=%b npc=%h r1=%h r2=%h se=%h rt=%0d rd=%0d exp all 0",
                     id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_reg1, id_ex_reg2,
                     id_ex_sign_ext, id_ex_instr20_16, id_ex_instr15_11);
        end
    endtask

    task automatic test_lw;
        drive(1'b1, 32'h8C12_0000, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex} !== {2'b11, 3'b010, 4'b0001}) begin
            errors++;
            $display("FAIL lw_ctrl got %b_%b_%b exp 11_010_0001", id_ex_wb, id_ex_m, id_ex_ex);
        end
        checks++;
        if ({id_ex_instr20_16, id_ex_instr15_11, id_ex_sign_ext} !== {5'd18, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL lw_fields got rt=%0d rd=%0d se=%h exp rt=18 rd=0 se=0",
                     id_ex_instr20_16, id_ex_instr15_11, id_ex_sign_ext);
        end
        checks++;
        if ({id_ex_npc, id_ex_reg1, id_ex_reg2} !== {32'h1000_0000, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL lw_data got npc=%h r1=%h r2=%h exp 10000000 0 0",
                     id_ex_npc, id_ex_reg1, id_ex_reg2);
        end
    endtask

    task automatic test_decode;
        if_id_npc = 32'h0000_0004;
        drive(1'b1, 32'h0000_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_instr15_11, id_ex_npc} !==
            {2'b10, 3'b000, 4'b1100, 5'd0, 32'h0000_0004}) begin
            errors++;
            $display("FAIL rtype got %b_%b_%b rd=%0d npc=%h exp 10_000_1100 rd=0 npc=4",
                     id_ex_wb, id_ex_m, id_ex_ex, id_ex_instr15_11, id_ex_npc);
        end
        drive(1'b1, 32'h2131_0010, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_instr20_16, id_ex_sign_ext} !==
            {2'b10, 3'b000, 4'b0001, 5'd17, 32'h0000_0010}) begin
            errors++;
            $display("FAIL addi got %b_%b_%b rt=%0d se=%h exp 10_000_0001 rt=17 se=00000010",
                     id_ex_wb, id_ex_m, id_ex_ex, id_ex_instr20_16, id_ex_sign_ext);
        end
        drive(1'b1, 32'h1000_0002, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_sign_ext} !==
            {2'b00, 3'b100, 4'b0010, 32'h0000_0002}) begin
            errors++;
            $display("FAIL beq got %b_%b_%b se=%h exp 00_100_0010 se=00000002",
                     id_ex_wb, id_ex_m, id_ex_ex, id_ex_sign_ext);
        end
        drive(1'b1, 32'hAD12_0000, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_instr20_16} !==
            {2'b00, 3'b001, 4'b0001, 5'd18}) begin
            errors++;
            $display("FAIL sw got %b_%b_%b rt=%0d exp 00_001_0001 rt=18",
                     id_ex_wb, id_ex_m, id_ex_ex, id_ex_instr20_16);
        end
    endtask

    task automatic test_sign_ext_nop;
        drive(1'b1, 32'h2008_FFFF, 1'b0, 32'h0, 5'd0);
        checks++;
        if (id_ex_sign_ext !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sext_neg got %h exp ffffffff", id_ex_sign_ext);
        end
        drive(1'b1, 32'hFC00_0000, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex} !== 9'd0) begin
            errors++;
            $display("FAIL undef_op got %b_%b_%b exp 00_000_0000", id_ex_wb, id_ex_m, id_ex_ex);
        end
    endtask

    task automatic test_write_path;
        // Write reg 8 via rd of an R-type instruction.
        drive(1'b1, 32'h0000_4020, 1'b1, 32'hDEAD_BEEF, 5'd8);
        drive(1'b1, 32'h0100_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if (id_ex_reg1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rf_read_r8 got %h exp deadbeef", id_ex_reg1);
        end
        // Same-cycle write and read of reg 8 returns the new data.
        drive(1'b1, 32'h0100_4020, 1'b1, 32'hCAFE_F00D, 5'd8);
        checks++;
        if (id_ex_reg1 !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL bypass_r8 got %h exp cafef00d", id_ex_reg1);
        end
        drive(1'b1, 32'h0100_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if (id_ex_reg1 !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rf_after_bypass got %h exp cafef00d", id_ex_reg1);
        end
        // Non-R-type write goes to rt (reg 9); read it back through the rt port.
        drive(1'b1, 32'h8C09_0000, 1'b1, 32'h0BAD_F00D, 5'd9);
        drive(1'b1, 32'h0009_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_reg1, id_ex_reg2} !== {32'h0, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL rf_read_r9_rt got r1=%h r2=%h exp 0 0badf00d", id_ex_reg1, id_ex_reg2);
        end
        checks++;
        drive(1'b1, 32'h0120_0020, 1'b0, 32'h0, 5'd0);
        if (id_ex_reg1 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rf_read_r9_rs got %h exp 0badf00d", id_ex_reg1);
        end
    endtask

    task automatic test_zero_reg;
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h1234_5678, 5'd0);
        checks++;
        if ({id_ex_reg1, id_ex_reg2} !== 64'd0) begin
            errors++;
            $display("FAIL r0_same_cycle got r1=%h r2=%h exp 0 0", id_ex_reg1, id_ex_reg2);
        end
        drive(1'b1, 32'h0000_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_reg1, id_ex_reg2} !== 64'd0) begin
            errors++;
            $display("FAIL r0_read got r1=%h r2=%h exp 0 0", id_ex_reg1, id_ex_reg2);
        end
    endtask

    task automatic test_reset_flush;
        if_id_npc = 32'h0000_0040;
        // Reset wins over a simultaneous write of reg 10.
        drive(1'b0, 32'h8C0A_0000, 1'b1, 32'h5555_AAAA, 5'd10);
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_reg1, id_ex_reg2,
             id_ex_sign_ext, id_ex_instr20_16, id_ex_instr15_11} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got wb=%b m=%b ex=%b npc=%h r1=%h r2=%h rt=%0d",
                     id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_reg1, id_ex_reg2,
                     id_ex_instr20_16);
        end
        drive(1'b1, 32'h0109_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if ({id_ex_reg1, id_ex_reg2} !== 64'd0) begin
            errors++;
            $display("FAIL regs_cleared r8/r9 got r1=%h r2=%h exp 0 0", id_ex_reg1, id_ex_reg2);
        end
        drive(1'b1, 32'h0140_0020, 1'b0, 32'h0, 5'd0);
        checks++;
        if (id_ex_reg1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_blocks_write r10 got %h exp 0", id_ex_reg1);
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        instr            = 32'h0;
        if_id_npc        = 32'h0;
        mem_wb_writedata = 32'h0;
        regWrite         = 1'b0;
`ifdef WB_ADDR_PORT_EN
        mem_wb_writereg  = 5'd0;
`endif
        @(negedge clk);
        test_reset;
        test_lw;
        test_decode;
        test_sign_ext_nop;
        test_write_path;
        test_zero_reg;
        test_reset_flush;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
